// File: rtl/uart_dbg_bridge.sv
// uart_dbg_bridge: UART-to-bus debug initiator.
//   A host PC sends 8N1 command frames on pad_rxd. Each command becomes one
//   single-word read or write on the peripheral data bus. Replies go out on
//   pad_txd.
//   Command format:
//     'W' (0x57) + addr[4, LE] + data[4, LE] -> one write, replies ACK 0x06
//     'R' (0x52) + addr[4, LE]               -> one read, replies 4 bytes LE
//     any other opcode                       -> replies NAK 0x15
// Ports:
//   clk_i      system clock
//   rst_n_i    synchronous active-low reset
//   pad_rxd    UART receive line (idle high, asynchronous to clk_i)
//   pad_txd    UART transmit line (idle high)
//   addr_o     bus address (holds its value between commands)
//   data_o     bus write data (holds its value between commands)
//   data_rd_o  one-cycle read strobe; data_i is sampled the following cycle
//   data_we_o  one-cycle write strobe
//   data_i     bus read data
//   busy_o     high from the end of the opcode byte until the response is sent
// Optional feature macro: UART_DBG_TIMEOUT_EN
//   When defined, a partial command is abandoned with a NAK if no byte
//   arrives for 16 frame times (160*CLK_DIV cycles).
// The command format carries four address and four data bytes, so
// DATA_BUS_WIDTH is expected to be 32.

`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif
`ifndef CPU_FREQ_HZ
`define CPU_FREQ_HZ 50000000
`endif

module uart_dbg_bridge #(
  parameter int CLK_DIV = `CPU_FREQ_HZ / 115200
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       pad_rxd,
  output logic                       pad_txd,
  output logic [`DATA_BUS_WIDTH-1:0] addr_o,
  output logic [`DATA_BUS_WIDTH-1:0] data_o,
  output logic                       data_rd_o,
  output logic                       data_we_o,
  input  logic [`DATA_BUS_WIDTH-1:0] data_i,
  output logic                       busy_o
);

  localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [7:0]    OP_RD     = 8'h52;
  localparam logic [7:0]    OP_WR     = 8'h57;
  localparam logic [7:0]    CH_ACK    = 8'h06;
  localparam logic [7:0]    CH_NAK    = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_e;

  // ---------------- RX front end ----------------
  logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid;

  // The byte is accepted at the middle of the stop bit; a low stop bit is
  // a framing error and simply produces no rx_valid.
  assign rx_valid = (rx_state_q == RX_STOP) && (rx_cnt_q == DIV_LAST) && rxd_sync_q;

  // Start detection needs a high-to-low transition so a line stuck low after
  // a framing error does not retrigger. The start bit is re-checked at its
  // midpoint to reject glitches, then every later sample lands mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_prev_q && !rxd_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // The synchronizer resets to the idle level so reset release is not
  // mistaken for a start bit.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rxd_meta_q <= pad_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- TX back end ----------------
  logic          tx_busy_q, tx_busy_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_last, tx_ready, tx_start;
  logic [7:0]    tx_byte;

  // TX counts as idle during the final cycle of a stop bit. A new byte
  // loaded then starts with no gap, which makes multi-byte replies
  // back-to-back.
  assign tx_last  = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cnt_q == DIV_LAST);
  assign tx_ready = !tx_busy_q || tx_last;
  assign pad_txd  = tx_shift_q[0];

  // The shifter back-fills with ones, so the line is high whenever TX is idle.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tx_start && tx_ready) begin
      tx_busy_d  = 1'b1;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_shift_d = {1'b1, tx_byte, 1'b0};
    end else if (tx_busy_q) begin
      if (tx_cnt_q == DIV_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

  // Reset forces the shifter to all ones, which cuts off any frame in flight
  // with the line held high.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // ---------------- Parser ----------------
  p_state_e    p_state_q, p_state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
  logic        bus_ph_q, bus_ph_d;
  logic [2:0]  resp_cnt_q, resp_cnt_d;
  logic [2:0]  resp_total;
  logic        timeout;

  assign resp_total = is_wr_q ? 3'd1 : 3'd4;
  assign addr_o     = addr_q;
  assign data_o     = data_q;

`ifdef UART_DBG_TIMEOUT_EN
  localparam int            TO_CYCLES = 160 * CLK_DIV;
  localparam int            TW        = $clog2(TO_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;

  // The inter-byte timer only runs while a command is being collected and
  // restarts on every received byte.
  always_comb begin
    timer_d = '0;
    if ((p_state_q == P_ADDR || p_state_q == P_DATA) && !rx_valid)
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) timer_q <= '0;
    else          timer_q <= timer_d;
  end

  assign timeout = (p_state_q == P_ADDR || p_state_q == P_DATA) &&
                   !rx_valid && (timer_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Parser state register together with its datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      p_state_q  <= P_CMD;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      bus_ph_q   <= 1'b0;
      resp_cnt_q <= '0;
    end else begin
      p_state_q  <= p_state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      bus_ph_q   <= bus_ph_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

  // Next-state logic. Address and data bytes shift in from the top, so
  // after four bytes the first one received sits in the low byte
  // (little-endian). Bytes that arrive during P_BUS and P_RESP are ignored.
  always_comb begin
    p_state_d  = p_state_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    bus_ph_d   = bus_ph_q;
    resp_cnt_d = resp_cnt_q;
    case (p_state_q)
      P_CMD: begin
        if (rx_valid && (rx_shift_q == OP_RD || rx_shift_q == OP_WR)) begin
          is_wr_d    = (rx_shift_q == OP_WR);
          byte_cnt_d = '0;
          p_state_d  = P_ADDR;
        end
      end
      P_ADDR: begin
        if (timeout) begin
          p_state_d = P_CMD;
        end else if (rx_valid) begin
          addr_d     = {rx_shift_q, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            bus_ph_d  = 1'b0;
            p_state_d = is_wr_q ? P_DATA : P_BUS;
          end
        end
      end
      P_DATA: begin
        if (timeout) begin
          p_state_d = P_CMD;
        end else if (rx_valid) begin
          data_d     = {rx_shift_q, data_q[31:8]};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            bus_ph_d  = 1'b0;
            p_state_d = P_BUS;
          end
        end
      end
      P_BUS: begin
        // A read needs a second cycle to capture data_i behind the strobe.
        resp_cnt_d = '0;
        if (is_wr_q) begin
          p_state_d = P_RESP;
        end else if (!bus_ph_q) begin
          bus_ph_d = 1'b1;
        end else begin
          rdata_d   = data_i;
          p_state_d = P_RESP;
        end
      end
      P_RESP: begin
        // Once every reply byte has been handed to TX, the end of the last
        // stop bit returns the parser to P_CMD.
        if (tx_start && tx_ready)
          resp_cnt_d = resp_cnt_q + 1'b1;
        else if (resp_cnt_q == resp_total && tx_last)
          p_state_d = P_CMD;
      end
      default: p_state_d = P_CMD;
    endcase
  end

  // Output logic. A NAK is only sent if TX can take it at that moment. If a
  // host floods bad opcodes faster than NAKs can drain, the extra NAKs are
  // dropped rather than queued.
  always_comb begin
    data_we_o = (p_state_q == P_BUS) && is_wr_q;
    data_rd_o = (p_state_q == P_BUS) && !is_wr_q && !bus_ph_q;
    busy_o    = (p_state_q != P_CMD);
    tx_start  = 1'b0;
    tx_byte   = CH_NAK;
    case (p_state_q)
      P_CMD:          tx_start = rx_valid && (rx_shift_q != OP_RD) && (rx_shift_q != OP_WR);
      P_ADDR, P_DATA: tx_start = timeout;
      P_RESP: begin
        tx_start = (resp_cnt_q < resp_total);
        if (is_wr_q) begin
          tx_byte = CH_ACK;
        end else begin
          case (resp_cnt_q[1:0])
            2'd0:    tx_byte = rdata_q[7:0];
            2'd1:    tx_byte = rdata_q[15:8];
            2'd2:    tx_byte = rdata_q[23:16];
            default: tx_byte = rdata_q[31:24];
          endcase
        end
      end
      default: tx_start = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// tb_uart_dbg_bridge: directed bench for uart_dbg_bridge at CLK_DIV = 8.
// Host bytes are bit-banged onto pad_rxd. A background monitor decodes
// pad_txd frames into a queue with their start cycles. A second monitor
// counts bus strobes and records addr_o/data_o on each strobe. A responder
// drives data_i = 0x1234_5678 only in the cycle after data_rd_o.

`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module tb_uart_dbg_bridge;

  localparam int CLK_DIV = 8;

  logic                       clk = 1'b0;
  logic                       rst_n_i;
  logic                       pad_rxd;
  logic                       pad_txd;
  logic [`DATA_BUS_WIDTH-1:0] addr_o;
  logic [`DATA_BUS_WIDTH-1:0] data_o;
  logic                       data_rd_o;
  logic                       data_we_o;
  logic [`DATA_BUS_WIDTH-1:0] data_i;
  logic                       busy_o;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;

  logic [7:0]  tx_q[$];
  int unsigned tx_t[$];
  logic        tx_stop[$];

  int          we_cnt   = 0;
  int          rd_cnt   = 0;
  int          both_cnt = 0;
  logic [31:0] we_addr  = '0;
  logic [31:0] we_data  = '0;
  logic [31:0] rd_addr  = '0;

  uart_dbg_bridge #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n_i),
    .pad_rxd  (pad_rxd),
    .pad_txd  (pad_txd),
    .addr_o   (addr_o),
    .data_o   (data_o),
    .data_rd_o(data_rd_o),
    .data_we_o(data_we_o),
    .data_i   (data_i),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Decode every pad_txd frame, sampling mid-bit on the falling clock edge.
  initial begin : tx_monitor
    logic        prev;
    logic [7:0]  b;
    int unsigned t0;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !pad_txd) begin
        t0 = cyc;
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = pad_txd;
        end
        repeat (CLK_DIV) @(negedge clk);
        tx_q.push_back(b);
        tx_t.push_back(t0);
        tx_stop.push_back(pad_txd);
      end
      prev = pad_txd;
    end
  end

  // Count bus strobes and record the bus state seen on each strobe.
  initial begin : strobe_monitor
    forever begin
      @(negedge clk);
      if (data_we_o) begin
        we_cnt++;
        we_addr = addr_o;
        we_data = data_o;
      end
      if (data_rd_o) begin
        rd_cnt++;
        rd_addr = addr_o;
      end
      if (data_we_o && data_rd_o) both_cnt++;
    end
  end

  // Read data is valid only in the cycle after the read strobe.
  initial begin : read_responder
    data_i = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (data_rd_o) begin
        @(posedge clk);
        #1 data_i = 32'h1234_5678;
        @(posedge clk);
        #1 data_i = 32'hFFFF_FFFF;
      end
    end
  end

  // Send one 8N1 frame on pad_rxd; stop_bit = 0 makes a framing error.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    pad_rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pad_rxd = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    pad_rxd = stop_bit;
    repeat (CLK_DIV) @(negedge clk);
    pad_rxd = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) until n response frames have been decoded.
  task automatic waitFrames(input int n, input int budget);
    int k;
    k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("tx_frame_count", 32'(tx_q.size()), 32'(n));
  endtask

  task automatic clearFrames();
    tx_q.delete();
    tx_t.delete();
    tx_stop.delete();
  endtask

  initial begin : stimulus
    int          k;
    int unsigned t_stall;
    logic [7:0]  wr_cmd[9];
    logic [7:0]  rd_cmd[5];
    logic [7:0]  rd_exp[4];

    wr_cmd = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rd_cmd = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h20};
    rd_exp = '{8'h78, 8'h56, 8'h34, 8'h12};

    // Reset held for 3 cycles.
    pad_rxd = 1'b1;
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pad_txd", 32'(pad_txd), 32'd1);
    checkOutput("rst_rd", 32'(data_rd_o), 32'd0);
    checkOutput("rst_we", 32'(data_we_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_addr", addr_o, 32'h0);
    checkOutput("rst_data", data_o, 32'h0);
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk);

    // Write command.
    $display("[TB] write 0xDEADBEEF to 0x20000010");
    applyStimulus(wr_cmd[0], 1'b1);
    checkOutput("busy_after_opcode", 32'(busy_o), 32'd1);
    for (int i = 1; i < 9; i++) applyStimulus(wr_cmd[i], 1'b1);
    waitFrames(1, 400);
    checkOutput("we_count", 32'(we_cnt), 32'd1);
    checkOutput("we_addr", we_addr, 32'h2000_0010);
    checkOutput("we_data", we_data, 32'hDEAD_BEEF);
    checkOutput("wr_rd_count", 32'(rd_cnt), 32'd0);
    if (tx_q.size() >= 1) begin
      checkOutput("ack_byte", 32'(tx_q[0]), 32'h06);
      checkOutput("ack_stop", 32'(tx_stop[0]), 32'd1);
    end
    repeat (2 * CLK_DIV) @(negedge clk);
    checkOutput("busy_after_ack", 32'(busy_o), 32'd0);
    clearFrames();

    // Read command.
    $display("[TB] read from 0x20000004");
    for (int i = 0; i < 5; i++) applyStimulus(rd_cmd[i], 1'b1);
    waitFrames(4, 1000);
    checkOutput("rd_count", 32'(rd_cnt), 32'd1);
    checkOutput("rd_addr", rd_addr, 32'h2000_0004);
    checkOutput("addr_hold", addr_o, 32'h2000_0004);
    checkOutput("data_hold", data_o, 32'hDEAD_BEEF);
    checkOutput("rd_we_count", 32'(we_cnt), 32'd1);
    checkOutput("strobes_together", 32'(both_cnt), 32'd0);
    if (tx_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkOutput("rd_byte", 32'(tx_q[i]), 32'(rd_exp[i]));
      for (int i = 1; i < 4; i++) checkOutput("rd_gap", tx_t[i] - tx_t[i-1], 32'(10 * CLK_DIV));
    end
    repeat (2 * CLK_DIV) @(negedge clk);
    checkOutput("busy_after_read", 32'(busy_o), 32'd0);
    clearFrames();

    // Invalid opcode.
    $display("[TB] invalid opcode 0x41");
    applyStimulus(8'h41, 1'b1);
    waitFrames(1, 200);
    if (tx_q.size() >= 1) checkOutput("nak_byte", 32'(tx_q[0]), 32'h15);
    checkOutput("nak_we_count", 32'(we_cnt), 32'd1);
    checkOutput("nak_rd_count", 32'(rd_cnt), 32'd1);
    checkOutput("nak_busy", 32'(busy_o), 32'd0);
    repeat (2 * CLK_DIV) @(negedge clk);
    clearFrames();

    // Framing error on a 'W' byte, then a bad opcode to prove P_CMD.
    $display("[TB] framing error");
    applyStimulus(8'h57, 1'b0);
    repeat (4 * CLK_DIV) @(negedge clk);
    checkOutput("ferr_busy", 32'(busy_o), 32'd0);
    checkOutput("ferr_no_tx", 32'(tx_q.size()), 32'd0);
    applyStimulus(8'h41, 1'b1);
    waitFrames(1, 200);
    if (tx_q.size() >= 1) checkOutput("ferr_then_nak", 32'(tx_q[0]), 32'h15);
    repeat (2 * CLK_DIV) @(negedge clk);
    clearFrames();

    // False start: 2-cycle low glitch.
    $display("[TB] false start glitch");
    pad_rxd = 1'b0;
    repeat (2) @(negedge clk);
    pad_rxd = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("glitch_no_tx", 32'(tx_q.size()), 32'd0);
    checkOutput("glitch_busy", 32'(busy_o), 32'd0);

    // Stalled command.
    $display("[TB] stalled read command");
    applyStimulus(8'h52, 1'b1);
    applyStimulus(8'h04, 1'b1);
    t_stall = cyc;
`ifdef UART_DBG_TIMEOUT_EN
    waitFrames(1, 1280 + 200);
    if (tx_q.size() >= 1) begin
      checkOutput("timeout_byte", 32'(tx_q[0]), 32'h15);
      checkOutput("timeout_delay_ok",
                  32'((tx_t[0] - t_stall >= 1270) && (tx_t[0] - t_stall <= 1290)), 32'd1);
    end
    repeat (2 * CLK_DIV) @(negedge clk);
    checkOutput("timeout_busy", 32'(busy_o), 32'd0);
`else
    repeat (1500) @(negedge clk);
    checkOutput("stall_busy", 32'(busy_o), 32'd1);
    checkOutput("stall_no_tx", 32'(tx_q.size()), 32'd0);
`endif
    checkOutput("stall_rd_count", 32'(rd_cnt), 32'd1);
    rst_n_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    checkOutput("stall_reset_busy", 32'(busy_o), 32'd0);
    repeat (4) @(negedge clk);
    clearFrames();

    // Reset in the middle of a NAK frame truncates it with the line high.
    $display("[TB] reset during transmit");
    applyStimulus(8'h41, 1'b1);
    k = 0;
    while (pad_txd && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("nak_started", 32'(pad_txd), 32'd0);
    repeat (3 * CLK_DIV) @(negedge clk);
    rst_n_i = 1'b0;
    @(negedge clk);
    checkOutput("trunc_pad_txd", 32'(pad_txd), 32'd1);
    checkOutput("trunc_busy", 32'(busy_o), 32'd0);
    rst_n_i = 1'b1;
    repeat (15 * CLK_DIV) @(negedge clk);
    checkOutput("trunc_idle_high", 32'(pad_txd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
